// File: rtl/ram_loader.sv
// ram_loader: byte-stream command port driving the second port of the
// 2K x 8 program/data RAM. Handles W (write), R (read back), G (release CPU)
// and H (hold CPU) commands from a byte source, and keeps the CPU in reset
// until released.
module ram_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  output logic        cpu_hold,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WRITE,
    RD_ADDR,
    RD_WAIT,
    RD_OUT
  } state_t;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;

  state_t      state;
  logic [1:0]  hdr_cnt;
  logic        is_read;
  logic [10:0] addr;
  logic [15:0] remaining;

  // Command parser, header capture, write/readback sequencing and CPU hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hdr_cnt   <= '0;
      is_read   <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      cpu_hold  <= 1'b1;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (in_data)
              CMD_W: begin
                state   <= HDR;
                hdr_cnt <= '0;
                is_read <= 1'b0;
                err     <= 1'b0;
              end
              CMD_R: begin
                state   <= HDR;
                hdr_cnt <= '0;
                is_read <= 1'b1;
                err     <= 1'b0;
              end
              CMD_G: begin
                cpu_hold <= 1'b0;
                err      <= 1'b0;
              end
              CMD_H: begin
                cpu_hold <= 1'b1;
                err      <= 1'b0;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        HDR: begin
          if (in_valid) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd0: addr[10:8]       <= in_data[2:0];
              2'd1: addr[7:0]        <= in_data;
              2'd2: remaining[15:8]  <= in_data;
              default: begin
                remaining[7:0] <= in_data;
                // Zero length: straight back to IDLE, no RAM access.
                if ({remaining[15:8], in_data} == 16'h0000)
                  state <= IDLE;
                else if (is_read)
                  state <= RD_ADDR;
                else
                  state <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          if (in_valid) begin
            addr      <= addr + 11'd1;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1)
              state <= IDLE;
          end
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          out_data <= ram_dout;
          state    <= RD_OUT;
        end
        RD_OUT: begin
          if (out_ready) begin
            addr      <= addr + 11'd1;
            remaining <= remaining - 16'd1;
            state     <= (remaining == 16'd1) ? IDLE : RD_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and RAM-port outputs decoded from the registered state; write
  // data passes straight through so each accepted byte lands the same cycle.
  always_comb begin
    in_ready  = (state == IDLE) || (state == HDR) || (state == WRITE);
    out_valid = (state == RD_OUT);
    busy      = (state != IDLE);
    ram_addr  = addr;
    ram_we    = (state == WRITE) && in_valid;
    ram_din   = (state == WRITE) ? in_data : 8'h00;
  end

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader: behavioural write-first RAM on the loader port,
// scoreboard queues for RAM writes and readback bytes, plus timing and
// protocol checks.
module tb_ram_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        cpu_hold;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  logic [18:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  mem       [0:2047];
  logic [7:0]  model_mem [0:2047];

  ram_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous RAM port
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= ram_we ? ram_din : mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every RAM write and every readback handshake
  always @(negedge clk) begin
    logic [18:0] e;
    logic [7:0]  r;
    if (ram_we) begin
      if (wq.size() == 0) check("wr_unexpected", {31'd0, ram_we}, 32'd0);
      else begin
        e = wq.pop_front();
        check("wr_addr", {21'd0, ram_addr}, {21'd0, e[18:8]});
        check("wr_data", {24'd0, ram_din}, {24'd0, e[7:0]});
      end
    end
    if (out_valid && out_ready) begin
      if (rq.size() == 0) check("rd_unexpected", {31'd0, out_valid}, 32'd0);
      else begin
        r = rq.pop_front();
        check("rd_data", {24'd0, out_data}, {24'd0, r});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int cnt;
    @(posedge clk); #1;
    in_data  = b;
    in_valid = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!in_ready && cnt < 50);
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic write_cmd(input logic [7:0] ah, input logic [7:0] al, input int n,
                           input logic [31:0] d);
    logic [10:0] a;
    logic [7:0]  b;
    a = {ah[2:0], al};
    send(8'h57); send(ah); send(al); send(8'h00); send(n[7:0]);
    for (int i = 0; i < n; i++) begin
      b = d[8*i +: 8];
      wq.push_back({a, b});
      model_mem[a] = b;
      send(b);
      a = a + 11'd1;
    end
    idle_in();
  endtask

  task automatic read_hdr(input logic [7:0] ah, input logic [7:0] al, input int n);
    logic [10:0] a;
    a = {ah[2:0], al};
    for (int i = 0; i < n; i++) begin
      rq.push_back(model_mem[a]);
      a = a + 11'd1;
    end
    send(8'h52); send(ah); send(al); send(8'h00); send(n[7:0]);
    idle_in();
  endtask

  // With out_ready high: first byte 3 cycles after len_lo, then every 3 cycles
  task automatic drain_timed(input int n);
    int cnt;
    for (int i = 0; i < n; i++) begin
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!out_valid && cnt < 20);
      if (i == 0) check("rd_first_lat", cnt, 3);
      else        check("rd_spacing", cnt, 3);
    end
    @(negedge clk);
    check("rd_end_valid", {31'd0, out_valid}, 32'd0);
    check("rd_end_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {21'd0, ram_addr}, 32'd0);
    check("rst_ram_din", {24'd0, ram_din}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0;
    int cnt;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset();

    // Write three bytes back-to-back
    write_cmd(8'h00, 8'h10, 3, 32'h00CCBBAA);
    @(negedge clk);
    check("wr_busy_after", {31'd0, busy}, 32'd0);
    check("wr_cpu_hold", {31'd0, cpu_hold}, 32'd1);

    // Read them back with out_ready held high
    out_ready = 1'b1;
    read_hdr(8'h00, 8'h10, 3);
    drain_timed(3);

    // Address wrap; addr_hi upper bits ignored on readback
    write_cmd(8'h07, 8'hFF, 2, 32'h00002211);
    read_hdr(8'hFF, 8'hFF, 2);
    drain_timed(2);

    // Backpressure: hold first byte for 5 cycles
    out_ready = 1'b0;
    read_hdr(8'h00, 8'h10, 2);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!out_valid && cnt < 20);
    check("bp_first_lat", cnt, 3);
    d0 = out_data;
    check("bp_first_data", {24'd0, d0}, 32'h000000AA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_stable", {24'd0, out_data}, {24'd0, d0});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (busy && cnt < 30);
    check("bp_done_busy", {31'd0, busy}, 32'd0);
    check("bp_drained", rq.size(), 0);

    // Protocol: bad byte, G, H, zero-length write
    send(8'h00); idle_in(); @(negedge clk);
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_busy", {31'd0, busy}, 32'd0);
    send(8'h47); idle_in(); @(negedge clk);
    check("g_err", {31'd0, err}, 32'd0);
    check("g_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    send(8'h48); idle_in(); @(negedge clk);
    check("h_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    send(8'h57); send(8'h00); send(8'h00); send(8'h00);
    check("len0_busy_hdr", {31'd0, busy}, 32'd1);
    send(8'h00); idle_in(); @(negedge clk);
    check("len0_busy_after", {31'd0, busy}, 32'd0);
    check("len0_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset after 2 of 4 payload bytes
    send(8'h57); send(8'h01); send(8'h00); send(8'h00); send(8'h04);
    wq.push_back({11'h100, 8'hA1}); model_mem[11'h100] = 8'hA1; send(8'hA1);
    wq.push_back({11'h101, 8'hB2}); model_mem[11'h101] = 8'hB2; send(8'hB2);
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset();
    check("mid_mem0", {24'd0, mem[11'h100]}, 32'h000000A1);
    check("mid_mem1", {24'd0, mem[11'h101]}, 32'h000000B2);
    send(8'h47); idle_in(); @(negedge clk);
    check("post_rst_cmd_hold", {31'd0, cpu_hold}, 32'd0);
    check("post_rst_cmd_busy", {31'd0, busy}, 32'd0);
    check("post_rst_cmd_err", {31'd0, err}, 32'd0);

    repeat (3) @(negedge clk);
    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Byte-stream loader/debug port that sits directly upstream of the 2K×8 dual-port program/data RAM and drives its second port. It accepts framed commands from a byte source (UART receiver), writes payload bytes into RAM, streams RAM contents back out for readback, and holds the CPU in reset until a load is released. The CPU keeps exclusive use of the RAM's first port.

## Interface
- no parameters; RAM depth fixed at 2048 bytes (11-bit address), data 8 bits
- clk  in  1  system clock; RAM port shares it
- rst  in  1  synchronous, active-high reset
- in_data  in  8  command/payload byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready at rising clk
- out_data  out  8  readback byte
- out_valid  out  1  out_data valid; held with stable data until accepted
- out_ready  in  1  consumer accepts when out_valid && out_ready
- ram_addr  out  11  RAM port address
- ram_din  out  8  RAM port write data
- ram_we  out  1  RAM port write enable
- ram_dout  in  8  RAM port read data; synchronous read, valid the cycle after ram_addr is presented
- cpu_hold  out  1  1 = CPU held in reset
- busy  out  1  1 whenever state ≠ IDLE
- err  out  1  sticky unknown-command flag; cleared by next valid command byte

## Operation
- Commands (first byte in IDLE): 0x57 'W' write, 0x52 'R' read, 0x47 'G' release CPU (cpu_hold←0), 0x48 'H' hold CPU (cpu_hold←1). Any other byte: err←1, stay IDLE. G/H take effect the cycle after acceptance, no header; repeats are no-ops.
- W/R header: 4 bytes addr_hi, addr_lo, len_hi, len_lo. Start address = {addr_hi[2:0], addr_lo}; addr_hi[7:3] ignored. Length = 16-bit {len_hi, len_lo}, byte count, 0 legal.
- States: IDLE → HDR (4-byte counter) → WRITE or RD_ADDR; read loop RD_ADDR → RD_WAIT → RD_OUT → RD_ADDR/IDLE.
- Length 0: return to IDLE the cycle after len_lo; no RAM access, no output.
- WRITE: in_ready=1; on each accepted byte, same cycle ram_we=1, ram_addr=current address, ram_din=in_data; address increments mod 2048 (0x7FF→0x000), remaining decrements; after last byte → IDLE.
- Read: RD_ADDR drives ram_addr; RD_WAIT latches ram_dout into out_data; RD_OUT holds out_valid=1 until out_ready; then address +1 mod 2048, remaining −1; remaining 0 → IDLE, else RD_ADDR.
- in_ready=1 in IDLE, HDR, WRITE; 0 in read states.
- ram_we=0 outside WRITE; ram_addr holds last value when idle.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0x00, ram_we=0, ram_addr=0, ram_din=0, cpu_hold=1, busy=0, err=0.
- Header and write bytes accepted back-to-back, one per cycle, zero stall.
- Write latency: byte accepted in cycle T is in RAM after the T rising edge; readable on the other port from T+1 (RAM is write-first).
- Read: len_lo accepted cycle T → RD_ADDR T+1 → RD_WAIT T+2 → out_valid=1 at T+3. Handshake in cycle X → next out_valid at X+3. Max throughput 1 byte / 3 cycles.
- out_valid deasserts the cycle after final handshake; busy deasserts same cycle.
- err set the cycle after the bad byte is accepted; cleared the cycle after a W/R/G/H byte is accepted.
- Reset mid-operation: immediate return to reset values; RAM bytes already written stay written; header/count discarded; cpu_hold=1.
- in_valid ignored while in_ready=0; out_ready ignored while out_valid=0.

## Test plan
- Reset, then W 00 10 00 03 AA BB CC back-to-back → ram_we pulses 3 cycles at 0x010/011/012 with AA/BB/CC; busy 0 the cycle after CC; cpu_hold stays 1.
- Preload via W, then R 00 10 00 03 with out_ready=1 → out_data AA,BB,CC; first out_valid 3 cycles after len_lo; spacing 3 cycles.
- Wrap: W 07 FF 00 02 11 22 → writes 0x7FF=11, 0x000=22; R 07 FF 00 02 returns 11,22; addr_hi=0xFF treated as 0x7.
- Backpressure: read 2 bytes with out_ready low 5 cycles → out_valid and out_data stable throughout; no byte lost or duplicated.
- Protocol: byte 0x00 → err=1, state IDLE; then G → err=0, cpu_hold=0; then H → cpu_hold=1; W hdr with len 0 → busy one header-length then IDLE, no ram_we.
- Reset asserted after 2 of 4 payload bytes → all reset values next cycle, first 2 bytes present in RAM, next byte parsed as a command.
